// File: rtl/gpu_cmd_pkg.sv
// Shared opcode, channel and state definitions for the command-issue stage.
package gpu_cmd_pkg;

  localparam logic [7:0] OP_SWAP      = 8'h01;
  localparam logic [7:0] OP_CLEAR     = 8'h02;
  localparam logic [7:0] OP_LOAD_EDGE = 8'h05;
  localparam logic [7:0] OP_STATUS    = 8'h08;

  localparam int CH_SWAP      = 0;
  localparam int CH_CLEAR     = 1;
  localparam int CH_LOAD_EDGE = 4;
  localparam int CH_STATUS    = 7;

  localparam int         DEF_NUM_CH          = 8;
  localparam int         DEF_SIZE            = 256;
  localparam int         DEF_OPCODE_BYTE     = 2;
  localparam logic [7:0] DEF_VSYNC_LOCK_MASK = 8'h01;
  localparam logic [7:0] DEF_BARRIER_MASK    = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/frame_lock_tracker.sv
// Per-channel frame locks (released on vsync falling edge) and short-lived
// pending flags that cover the gap between a start pulse and engine busy.
module frame_lock_tracker #(
  parameter int                NUM_CH    = 8,
  parameter logic [NUM_CH-1:0] LOCK_MASK = '1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vsync_i,
  input  logic [NUM_CH-1:0] set_i,
  input  logic [NUM_CH-1:0] ch_busy_i,
  output logic [NUM_CH-1:0] lock_o,
  output logic [NUM_CH-1:0] pending_o,
  output logic              vs_evt_o
);

  logic              vs_q;
  logic [NUM_CH-1:0] lock_q, lock_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] age_q, age_d;

  assign vs_evt_o  = vs_q & ~vsync_i;
  // A fresh lock raised on the vsync cycle survives the clear.
  assign lock_d    = (lock_q & ~{NUM_CH{vs_evt_o}}) | (set_i & LOCK_MASK);
  assign lock_o    = lock_q;
  assign pending_o = pend_q;

  // Pending drops on the first busy cycle, or after two cycles if busy never comes.
  always_comb begin
    pend_d = pend_q;
    age_d  = age_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (set_i[i]) begin
        pend_d[i] = 1'b1;
        age_d[i]  = 1'b0;
      end else if (pend_q[i] && (ch_busy_i[i] || age_q[i])) begin
        pend_d[i] = 1'b0;
        age_d[i]  = 1'b0;
      end else if (pend_q[i]) begin
        age_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q   <= 1'b1;
      lock_q <= '0;
      pend_q <= '0;
      age_q  <= '0;
    end else begin
      vs_q   <= vsync_i;
      lock_q <= lock_d;
      pend_q <= pend_d;
      age_q  <= age_d;
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Pops packets from a FWFT FIFO, decodes the opcode to a channel and issues a
// one-hot start pulse once the channel's busy/lock/barrier hazards are clear.
module cmd_dispatcher
  import gpu_cmd_pkg::*;
#(
  parameter int                NUM_CH          = DEF_NUM_CH,
  parameter int                SIZE            = DEF_SIZE,
  parameter int                OPCODE_BYTE     = DEF_OPCODE_BYTE,
  parameter logic [NUM_CH-1:0] VSYNC_LOCK_MASK = NUM_CH'(DEF_VSYNC_LOCK_MASK),
  parameter logic [NUM_CH-1:0] BARRIER_MASK    = NUM_CH'(DEF_BARRIER_MASK)
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                fifo_empty,
  input  logic [8*SIZE-1:0]   fifo_data,
  output logic                rd_en,
  input  logic                vsync,
  input  logic [NUM_CH-1:0]   ch_busy,
  output logic [NUM_CH-1:0]   cmd,
  output logic [8*SIZE-1:0]   cmd_packet,
  output logic [NUM_CH-1:0]   busy_status,
  output logic                stall,
  output logic                err_opcode,
  output logic [7:0]          err_count
);

  state_t              state_q, state_d;
  logic [7:0]          opc;
  logic [NUM_CH-1:0]   sel, lock, lock_view, pending, issue_set;
  logic                opc_ok, hazard, vs_evt;
  logic                rd_en_q, rd_en_d, stall_q, stall_d, err_q, err_d;
  logic [NUM_CH-1:0]   cmd_q, cmd_d, busy_status_q;
  logic [7:0]          err_count_q, err_count_d;
  logic [8*SIZE-1:0]   cmd_packet_q;

  frame_lock_tracker #(
    .NUM_CH    (NUM_CH),
    .LOCK_MASK (VSYNC_LOCK_MASK)
  ) u_lock (
    .clk_i     (CLK),
    .rst_ni    (rst),
    .vsync_i   (vsync),
    .set_i     (issue_set),
    .ch_busy_i (ch_busy),
    .lock_o    (lock),
    .pending_o (pending),
    .vs_evt_o  (vs_evt)
  );

  assign opc = fifo_data[8*OPCODE_BYTE +: 8];

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) sel[i] = (opc == 8'(i + 1));
  end
  assign opc_ok = |sel;

  // The vsync event frees locks in the cycle it is seen, so a held packet can
  // issue on that same edge and re-lock.
  assign lock_view = lock & ~{NUM_CH{vs_evt}};

  assign hazard = (|(sel & (ch_busy | lock_view | pending)))
               || ((|(sel & BARRIER_MASK)) && (|((ch_busy | pending) & ~sel)))
               || (|(pending & BARRIER_MASK & ~sel));

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_CHECK;
      S_CHECK: begin
        if (fifo_empty)               state_d = S_IDLE;
        else if (!opc_ok || !hazard)  state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en_d     = 1'b0;
    cmd_d       = '0;
    stall_d     = 1'b0;
    err_d       = 1'b0;
    issue_set   = '0;
    err_count_d = err_count_q;
    if (state_q == S_CHECK && !fifo_empty) begin
      if (!opc_ok) begin
        rd_en_d = 1'b1;
        err_d   = 1'b1;
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end else if (hazard) begin
        stall_d = 1'b1;
      end else begin
        rd_en_d   = 1'b1;
        cmd_d     = sel;
        issue_set = sel;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      rd_en_q       <= 1'b0;
      cmd_q         <= '0;
      stall_q       <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
      cmd_packet_q  <= '0;
      busy_status_q <= '0;
    end else begin
      rd_en_q       <= rd_en_d;
      cmd_q         <= cmd_d;
      stall_q       <= stall_d;
      err_q         <= err_d;
      err_count_q   <= err_count_d;
      busy_status_q <= ch_busy | lock | pending;
      if (|issue_set) cmd_packet_q <= fifo_data;
    end
  end

  assign rd_en       = rd_en_q;
  assign cmd         = cmd_q;
  assign cmd_packet  = cmd_packet_q;
  assign busy_status = busy_status_q;
  assign stall       = stall_q;
  assign err_opcode  = err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed scoreboard bench: stimulus queues expected issues, a negedge monitor
// pops and compares whenever the dispatcher raises a start pulse.
module tb_cmd_dispatcher;
  import gpu_cmd_pkg::*;

  localparam int NCH = 8;
  localparam int SZ  = 256;
  localparam int PW  = 8 * SZ;

  typedef logic [PW-1:0] pkt_t;
  typedef struct {
    logic [NCH-1:0] cmd;
    pkt_t           pkt;
  } exp_t;

  logic           CLK = 1'b0;
  logic           rst;
  logic           fifo_empty = 1'b1;
  pkt_t           fifo_data  = '0;
  logic           rd_en;
  logic           vsync;
  logic [NCH-1:0] ch_busy;
  logic [NCH-1:0] cmd;
  pkt_t           cmd_packet;
  logic [NCH-1:0] busy_status;
  logic           stall;
  logic           err_opcode;
  logic [7:0]     err_count;

  pkt_t fq[$];
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, err_seen = 0;

  cmd_dispatcher dut (
    .CLK         (CLK),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .rd_en       (rd_en),
    .vsync       (vsync),
    .ch_busy     (ch_busy),
    .cmd         (cmd),
    .cmd_packet  (cmd_packet),
    .busy_status (busy_status),
    .stall       (stall),
    .err_opcode  (err_opcode),
    .err_count   (err_count)
  );

  always #5 CLK = ~CLK;

  // FWFT FIFO model: the only driver of fifo_empty/fifo_data.
  always @(negedge CLK) begin
    if (rd_en && fq.size() > 0) void'(fq.pop_front());
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  logic [NCH-1:0] prev_cmd = '0;
  always @(negedge CLK) begin
    if (!rst) prev_cmd = '0;
    else begin
      if (err_opcode) err_seen++;
      if (cmd != '0) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_cmd: got %0h, expected no issue", cmd);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("cmd_onehot", 32'(cmd), 32'(e.cmd));
          chk("cmd_pulse_width", 32'(prev_cmd), 32'd0);
          n_chk++;
          if (cmd_packet !== e.pkt) begin
            n_fail++;
            $display("FAIL cmd_packet: got lo %h hi %h, expected lo %h hi %h",
                     cmd_packet[63:0], cmd_packet[PW-1 -: 64], e.pkt[63:0], e.pkt[PW-1 -: 64]);
          end
        end
      end
      prev_cmd = cmd;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  function automatic pkt_t mk_pkt(input logic [7:0] opc, input logic [7:0] tag);
    pkt_t p;
    p = '0;
    for (int i = 0; i < SZ; i++) p[8*i +: 8] = tag ^ 8'(i);
    p[8*2 +: 8] = opc;
    return p;
  endfunction

  task automatic expect_issue(input logic [NCH-1:0] c, input pkt_t p);
    exp_t e;
    e.cmd = c;
    e.pkt = p;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int max, input string nm);
    int k = 0;
    while (sb.size() != 0 && k < max) begin
      tick();
      k++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d issues outstanding after %0d cycles, expected 0", nm, sb.size(), max);
      sb.delete();
    end
  endtask

  initial begin
    pkt_t p, p2;
    int bad, rds, k;
    rst = 1'b0; vsync = 1'b1; ch_busy = '0;
    repeat (3) tick();

    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_cmd_packet", 32'(|cmd_packet), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Single CLEAR issue and latency
    p = mk_pkt(OP_CLEAR, 8'h11);
    expect_issue(8'h02, p);
    fq.push_back(p);
    tick();
    chk("t1_no_early_cmd", 32'(cmd), 0);
    chk("t1_no_early_rd", 32'(rd_en), 0);
    tick();
    chk("t1_cmd_at_t2", 32'(cmd), 32'h02);
    chk("t1_rd_en_at_t2", 32'(rd_en), 1);
    tick();
    chk("t1_rd_en_one_cycle", 32'(rd_en), 0);
    wait_sb(4, "t1_issue");

    // Frame lock on SWAP holds the second packet until vsync falls
    p  = mk_pkt(OP_SWAP, 8'h21);
    p2 = mk_pkt(OP_SWAP, 8'h22);
    expect_issue(8'h01, p);
    fq.push_back(p);
    fq.push_back(p2);
    wait_sb(6, "t2_first");
    repeat (3) tick();
    chk("t2_busy_status0", 32'(busy_status[0]), 1);
    chk("t2_stall", 32'(stall), 1);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (stall !== 1'b1 || rd_en !== 1'b0 || cmd !== '0) bad++;
    end
    chk("t2_hold_bad_cycles", bad, 0);
    expect_issue(8'h01, p2);
    vsync = 1'b0;
    wait_sb(4, "t2_after_vsync");
    tick();
    vsync = 1'b1;

    // Busy engine holds LOAD_EDGE
    ch_busy = 8'h10;
    p = mk_pkt(OP_LOAD_EDGE, 8'h33);
    fq.push_back(p);
    rds = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_en) rds++;
    end
    chk("t3_stall", 32'(stall), 1);
    chk("t3_no_pop", rds, 0);
    expect_issue(8'h10, p);
    ch_busy = '0;
    wait_sb(4, "t3_issue");

    // Unknown opcodes are popped and counted
    fq.push_back(mk_pkt(8'h00, 8'h40));
    fq.push_back(mk_pkt(8'h0A, 8'h41));
    repeat (10) tick();
    chk("t4_err_pulses", err_seen, 2);
    chk("t4_err_count", 32'(err_count), 2);
    chk("t4_fifo_drained", fq.size(), 0);
    for (int i = 0; i < 298; i++) fq.push_back(mk_pkt((i % 2) ? 8'hFF : 8'h09, 8'(i)));
    k = 0;
    while (fq.size() != 0 && k < 1500) begin tick(); k++; end
    repeat (4) tick();
    chk("t4_bad_drained", fq.size(), 0);
    chk("t4_err_saturate", 32'(err_count), 255);
    chk("t4_err_pulses_total", err_seen, 300);

    // Barrier: SWAP waits for other engines to idle
    vsync = 1'b0; tick(); tick(); vsync = 1'b1;
    ch_busy = 8'h02;
    p = mk_pkt(OP_SWAP, 8'h55);
    fq.push_back(p);
    repeat (8) tick();
    chk("t5_barrier_stall", 32'(stall), 1);
    expect_issue(8'h01, p);
    ch_busy = '0;
    wait_sb(4, "t5_issue");

    // Asynchronous reset during a hold
    ch_busy = 8'h10;
    p = mk_pkt(OP_LOAD_EDGE, 8'h66);
    fq.push_back(p);
    repeat (5) tick();
    chk("t6_stall_before_rst", 32'(stall), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_rd_en", 32'(rd_en), 0);
    chk("t6_rst_cmd", 32'(cmd), 0);
    chk("t6_rst_stall", 32'(stall), 0);
    chk("t6_rst_busy_status", 32'(busy_status), 0);
    chk("t6_rst_err_count", 32'(err_count), 0);
    chk("t6_rst_cmd_packet", 32'(|cmd_packet), 0);
    chk("t6_head_kept", fq.size(), 1);
    ch_busy = '0;
    tick();
    rst = 1'b1;
    expect_issue(8'h10, p);
    wait_sb(8, "t6_issue_after_rst");
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
